// File: rtl/pkt_pkg.sv
// pkt_pkg
// Shared types and defaults for the packet link arbiter.
//   ID_W, FLIT_W    : widths taken from the global PKT_ID_W / PKT_FLIT_W defines
//   N_PORT_DEF      : default number of inbound link ports
//   STARVE_LIM_DEF  : default QoS grants allowed while a non-QoS head waits
//   pkt_t           : one packet (qos, ptype, src, tgt, data)
`ifndef PKT_ID_W
`define PKT_ID_W 4
`endif
`ifndef PKT_FLIT_W
`define PKT_FLIT_W 32
`endif

package pkt_pkg;

  localparam int ID_W           = `PKT_ID_W;
  localparam int FLIT_W         = `PKT_FLIT_W;
  localparam int N_PORT_DEF     = 7;
  localparam int STARVE_LIM_DEF = 8;

  // "type" is a keyword, so the packet type field is called ptype
  typedef struct packed {
    logic              qos;
    logic [1:0]        ptype;
    logic [ID_W-1:0]   src;
    logic [ID_W-1:0]   tgt;
    logic [FLIT_W-1:0] data;
  } pkt_t;

endpackage

// File: rtl/pkt_fifo2.sv
// pkt_fifo2
// Two-entry packet FIFO used once per inbound link port.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push_i      : offer pkt_i; taken only while notFull_o is high
//   pkt_i       : packet to write
//   pop_i       : remove the head; ignored when empty
//   head_o      : packet at the head of the FIFO
//   empty_o     : FIFO holds no packet
//   notFull_o   : registered space-available flag (used directly as in_rdy)
module pkt_fifo2
  import pkt_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic push_i,
  input  pkt_t pkt_i,
  input  logic pop_i,
  output pkt_t head_o,
  output logic empty_o,
  output logic notFull_o
);

  pkt_t       mem_q [2];
  logic       wrPtr_q;
  logic       rdPtr_q;
  logic [1:0] count_q;
  logic [1:0] count_d;
  logic       notFull_q;
  logic       doPush;
  logic       doPop;

  assign doPush = push_i && notFull_q;
  assign doPop  = pop_i && (count_q != 2'd0);

  // a simultaneous push and pop leaves the occupancy unchanged
  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  // notFull is computed from the next occupancy so the ready flag is a
  // plain flop with no path from the downstream ready
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wrPtr_q   <= 1'b0;
      rdPtr_q   <= 1'b0;
      count_q   <= 2'd0;
      notFull_q <= 1'b1;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= pkt_i;
        wrPtr_q        <= ~wrPtr_q;
      end
      if (doPop) begin
        rdPtr_q <= ~rdPtr_q;
      end
      count_q   <= count_d;
      notFull_q <= (count_d != 2'd2);
    end
  end

  assign head_o    = mem_q[rdPtr_q];
  assign empty_o   = (count_q == 2'd0);
  assign notFull_o = notFull_q;

endmodule

// File: rtl/pkt_link_arb.sv
// pkt_link_arb
// Merges N_PORT inbound packet links into one output register stage.
// Each port is buffered by a pkt_fifo2; QoS heads win over plain heads,
// round-robin inside the chosen class, with a starvation limit that forces
// a plain grant after STARVE_LIM consecutive QoS grants.
//   clk, rst_n                         : clock, asynchronous active-low reset
//   in_vld/in_rdy                      : per-port handshake (in_rdy registered)
//   in_qos/in_type/in_src/in_tgt/in_data : per-port packed packet fields
//   out_vld/out_rdy                    : merged output handshake
//   out_qos/out_type/out_src/out_tgt/out_data : merged packet fields
//   out_port                           : port the current output packet came from
module pkt_link_arb
  import pkt_pkg::*;
#(
  parameter int N_PORT     = N_PORT_DEF,
  parameter int STARVE_LIM = STARVE_LIM_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_PORT-1:0]        in_vld,
  output logic [N_PORT-1:0]        in_rdy,
  input  logic [N_PORT-1:0]        in_qos,
  input  logic [2*N_PORT-1:0]      in_type,
  input  logic [ID_W*N_PORT-1:0]   in_src,
  input  logic [ID_W*N_PORT-1:0]   in_tgt,
  input  logic [FLIT_W*N_PORT-1:0] in_data,
  output logic                     out_vld,
  input  logic                     out_rdy,
  output logic                     out_qos,
  output logic [1:0]               out_type,
  output logic [ID_W-1:0]          out_src,
  output logic [ID_W-1:0]          out_tgt,
  output logic [FLIT_W-1:0]        out_data,
  output logic [2:0]               out_port
);

  localparam int STARVE_W = $clog2(STARVE_LIM + 1);

  pkt_t                inPkt   [N_PORT];
  pkt_t                headPkt [N_PORT];
  logic [N_PORT-1:0]   fifoEmpty;
  logic [N_PORT-1:0]   fifoPop;
  logic [N_PORT-1:0]   headQos;
  logic [N_PORT-1:0]   nonEmpty;
  logic [N_PORT-1:0]   qosReq;
  logic [N_PORT-1:0]   plainReq;
  logic [N_PORT-1:0]   cand;
  logic                starveForce;
  logic                loadOut;
  logic                found;
  logic [2:0]          grantIdx;

  logic                outVld_q;
  pkt_t                outPkt_q;
  logic [2:0]          outPort_q;
  logic [2:0]          rrPtr_q;
  logic [STARVE_W-1:0] starveCnt_q;
  logic [STARVE_W-1:0] starveCnt_d;

  always_comb begin
    for (int i = 0; i < N_PORT; i++) begin
      inPkt[i].qos   = in_qos[i];
      inPkt[i].ptype = in_type[2*i +: 2];
      inPkt[i].src   = in_src[ID_W*i +: ID_W];
      inPkt[i].tgt   = in_tgt[ID_W*i +: ID_W];
      inPkt[i].data  = in_data[FLIT_W*i +: FLIT_W];
      headQos[i]     = headPkt[i].qos;
    end
  end

  for (genvar g = 0; g < N_PORT; g++) begin : gFifo
    pkt_fifo2 uFifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (in_vld[g]),
      .pkt_i     (inPkt[g]),
      .pop_i     (fifoPop[g]),
      .head_o    (headPkt[g]),
      .empty_o   (fifoEmpty[g]),
      .notFull_o (in_rdy[g])
    );
  end

  assign nonEmpty    = ~fifoEmpty;
  assign qosReq      = nonEmpty & headQos;
  assign plainReq    = nonEmpty & ~headQos;
  assign starveForce = (starveCnt_q == STARVE_W'(STARVE_LIM)) && (|plainReq);
  assign cand        = starveForce ? plainReq : ((|qosReq) ? qosReq : nonEmpty);
  assign loadOut     = (!outVld_q || out_rdy) && (|nonEmpty);

  // round-robin search starts one past the last granted port
  always_comb begin
    found    = 1'b0;
    grantIdx = 3'd0;
    for (int k = 1; k <= N_PORT; k++) begin
      if (!found && cand[(int'(rrPtr_q) + k) % N_PORT]) begin
        found    = 1'b1;
        grantIdx = 3'((int'(rrPtr_q) + k) % N_PORT);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_PORT; i++) begin
      fifoPop[i] = loadOut && (grantIdx == 3'(i));
    end
  end

  // counts QoS grants taken past a waiting plain head; any plain grant or
  // the absence of a waiting plain head restarts the count
  always_comb begin
    starveCnt_d = starveCnt_q;
    if (!(|plainReq)) begin
      starveCnt_d = '0;
    end else if (loadOut) begin
      starveCnt_d = headPkt[grantIdx].qos ? (starveCnt_q + STARVE_W'(1)) : '0;
    end
  end

  // output fields keep their value while stalled or idle; only a load changes them
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outVld_q    <= 1'b0;
      outPkt_q    <= '0;
      outPort_q   <= 3'd0;
      rrPtr_q     <= 3'(N_PORT - 1);
      starveCnt_q <= '0;
    end else begin
      starveCnt_q <= starveCnt_d;
      if (loadOut) begin
        outVld_q  <= 1'b1;
        outPkt_q  <= headPkt[grantIdx];
        outPort_q <= grantIdx;
        rrPtr_q   <= grantIdx;
      end else if (out_rdy) begin
        outVld_q <= 1'b0;
      end
    end
  end

  assign out_vld  = outVld_q;
  assign out_qos  = outPkt_q.qos;
  assign out_type = outPkt_q.ptype;
  assign out_src  = outPkt_q.src;
  assign out_tgt  = outPkt_q.tgt;
  assign out_data = outPkt_q.data;
  assign out_port = outPort_q;

endmodule

// File: tb/tb_pkt_link_arb.sv
// tb_pkt_link_arb
// Directed bench for pkt_link_arb with a queue-level reference model that is
// compared against the DUT on every falling clock edge, plus literal checks.
module tb_pkt_link_arb;
  import pkt_pkg::*;

  localparam int NP  = 7;
  localparam int LIM = 8;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NP-1:0]        in_vld = '0;
  logic [NP-1:0]        in_rdy;
  logic [NP-1:0]        in_qos = '0;
  logic [2*NP-1:0]      in_type = '0;
  logic [ID_W*NP-1:0]   in_src = '0;
  logic [ID_W*NP-1:0]   in_tgt = '0;
  logic [FLIT_W*NP-1:0] in_data = '0;
  logic                 out_vld;
  logic                 out_rdy = 1'b1;
  logic                 out_qos;
  logic [1:0]           out_type;
  logic [ID_W-1:0]      out_src;
  logic [ID_W-1:0]      out_tgt;
  logic [FLIT_W-1:0]    out_data;
  logic [2:0]           out_port;

  int testsRun = 0;
  int testsFailed = 0;

  pkt_link_arb #(.N_PORT(NP), .STARVE_LIM(LIM)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (in_vld),
    .in_rdy   (in_rdy),
    .in_qos   (in_qos),
    .in_type  (in_type),
    .in_src   (in_src),
    .in_tgt   (in_tgt),
    .in_data  (in_data),
    .out_vld  (out_vld),
    .out_rdy  (out_rdy),
    .out_qos  (out_qos),
    .out_type (out_type),
    .out_src  (out_src),
    .out_tgt  (out_tgt),
    .out_data (out_data),
    .out_port (out_port)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: per-port packet lists of capacity 2, one output slot,
  // last-grant pointer and count of QoS grants past a waiting plain head.
  pkt_t          mq [NP][2];
  int            mCnt [NP];
  logic          mVld = 1'b0;
  pkt_t          mOut = '0;
  int            mPort = 0;
  int            mPtr = NP - 1;
  int            mStarve = 0;
  logic [NP-1:0] mRdy = '1;

  task automatic modelReset();
    for (int i = 0; i < NP; i++) mCnt[i] = 0;
    mVld = 1'b0;
    mOut = '0;
    mPort = 0;
    mPtr = NP - 1;
    mStarve = 0;
    mRdy = '1;
  endtask

  task automatic modelStep();
    logic [NP-1:0] rdyBefore;
    bit anyQos, anyPlain, anyPkt, canLoad, force_, grantedQos, ok;
    int g, p;
    pkt_t np;
    anyQos = 0; anyPlain = 0; anyPkt = 0; grantedQos = 0;
    for (int i = 0; i < NP; i++) begin
      rdyBefore[i] = (mCnt[i] < 2);
      if (mCnt[i] > 0) begin
        anyPkt = 1;
        if (mq[i][0].qos) anyQos = 1; else anyPlain = 1;
      end
    end
    canLoad = (!mVld || out_rdy) && anyPkt;
    if (canLoad) begin
      force_ = (mStarve == LIM) && anyPlain;
      g = -1;
      for (int k = 1; k <= NP; k++) begin
        p = (mPtr + k) % NP;
        if (mCnt[p] > 0) begin
          if (force_) ok = !mq[p][0].qos;
          else if (anyQos) ok = mq[p][0].qos;
          else ok = 1;
          if (g < 0 && ok) g = p;
        end
      end
      grantedQos = mq[g][0].qos;
      mOut = mq[g][0];
      mPort = g;
      mVld = 1'b1;
      mPtr = g;
      mq[g][0] = mq[g][1];
      mCnt[g]--;
    end else if (out_rdy) begin
      mVld = 1'b0;
    end
    if (!anyPlain) mStarve = 0;
    else if (canLoad) mStarve = grantedQos ? mStarve + 1 : 0;
    for (int i = 0; i < NP; i++) begin
      if (in_vld[i] && rdyBefore[i]) begin
        np.qos   = in_qos[i];
        np.ptype = in_type[2*i +: 2];
        np.src   = in_src[ID_W*i +: ID_W];
        np.tgt   = in_tgt[ID_W*i +: ID_W];
        np.data  = in_data[FLIT_W*i +: FLIT_W];
        mq[i][mCnt[i]] = np;
        mCnt[i]++;
      end
      mRdy[i] = (mCnt[i] < 2);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) modelReset();
    else modelStep();
  end

  always @(negedge clk) begin
    checkOutput("cmp_out_vld", out_vld, mVld);
    checkOutput("cmp_in_rdy", in_rdy, mRdy);
    if (mVld) begin
      checkOutput("cmp_out_pkt", {out_qos, out_type, out_src, out_tgt, out_data}, mOut);
      checkOutput("cmp_out_port", out_port, mPort);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int p, input bit v, input bit q, input logic [1:0] ty,
                               input logic [ID_W-1:0] s, input logic [ID_W-1:0] t,
                               input logic [FLIT_W-1:0] d);
    in_vld[p]                 = v;
    in_qos[p]                 = q;
    in_type[2*p +: 2]         = ty;
    in_src[ID_W*p +: ID_W]    = s;
    in_tgt[ID_W*p +: ID_W]    = t;
    in_data[FLIT_W*p +: FLIT_W] = d;
  endtask

  task automatic doReset();
    in_vld = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_rdy = 1'b1;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int n6;
    bit seen;
    out_rdy = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    checkOutput("rst_out_vld", out_vld, 0);
    checkOutput("rst_in_rdy", in_rdy, 7'h7f);
    checkOutput("rst_out_port", out_port, 0);
    checkOutput("rst_out_data", out_data, 0);

    // single packet on port 3, visible two cycles later
    applyStimulus(3, 1, 0, 2'd1, 4'd5, 4'd9, 32'hA5A5_0003);
    tick();
    in_vld = '0;
    checkOutput("lat_c1_vld", out_vld, 0);
    tick();
    checkOutput("lat_c2_vld", out_vld, 1);
    checkOutput("lat_port", out_port, 3);
    checkOutput("lat_src", out_src, 5);
    checkOutput("lat_tgt", out_tgt, 9);
    checkOutput("lat_type", out_type, 1);
    checkOutput("lat_data", out_data, 32'hA5A5_0003);
    tick();
    checkOutput("lat_c3_vld", out_vld, 0);
    doReset();

    // three plain packets at once drain 0, 2, 5
    applyStimulus(0, 1, 0, 2'd0, 4'd0, 4'd1, 32'h100);
    applyStimulus(2, 1, 0, 2'd0, 4'd2, 4'd1, 32'h102);
    applyStimulus(5, 1, 0, 2'd0, 4'd5, 4'd1, 32'h105);
    tick();
    in_vld = '0;
    tick();
    checkOutput("rr_first", out_port, 0);
    tick();
    checkOutput("rr_second", out_port, 2);
    tick();
    checkOutput("rr_third", out_port, 5);
    checkOutput("rr_third_vld", out_vld, 1);
    tick();
    checkOutput("rr_idle", out_vld, 0);
    doReset();

    // QoS head beats a plain head
    applyStimulus(1, 1, 0, 2'd2, 4'd1, 4'd3, 32'h201);
    applyStimulus(4, 1, 1, 2'd3, 4'd4, 4'd3, 32'h204);
    tick();
    in_vld = '0;
    tick();
    checkOutput("qos_first", out_port, 4);
    checkOutput("qos_first_qos", out_qos, 1);
    tick();
    checkOutput("qos_second", out_port, 1);
    doReset();

    // port 6 streams QoS, port 0 waits with one plain packet
    applyStimulus(0, 1, 0, 2'd0, 4'd0, 4'd7, 32'hB0);
    applyStimulus(6, 1, 1, 2'd1, 4'd6, 4'd7, 32'h600);
    tick();
    in_vld[0] = 1'b0;
    n6 = 0;
    seen = 0;
    for (int c = 1; c <= 40; c++) begin
      applyStimulus(6, 1, 1, 2'd1, 4'd6, 4'd7, 32'h600 + 32'(c));
      if (out_vld && out_port == 3'd6) n6++;
      else if (out_vld && out_port == 3'd0) begin
        seen = 1;
        break;
      end
      tick();
    end
    checkOutput("starve_seen", seen, 1);
    checkOutput("starve_qos_grants", n6, 8);
    doReset();

    // stalled output: port 2 fills its FIFO behind a held output packet
    out_rdy = 1'b0;
    applyStimulus(2, 1, 0, 2'd1, 4'd2, 4'd8, 32'hC0A);
    tick();
    applyStimulus(2, 1, 0, 2'd1, 4'd2, 4'd8, 32'hC0B);
    tick();
    applyStimulus(2, 1, 0, 2'd1, 4'd2, 4'd8, 32'hC0C);
    tick();
    in_vld = '0;
    checkOutput("full_in_rdy2", in_rdy[2], 0);
    checkOutput("full_vld", out_vld, 1);
    checkOutput("full_port", out_port, 2);
    checkOutput("hold_data0", out_data, 32'hC0A);
    tick();
    checkOutput("hold_data1", out_data, 32'hC0A);
    tick();
    checkOutput("hold_data2", out_data, 32'hC0A);
    out_rdy = 1'b1;
    tick();
    checkOutput("drain_b", out_data, 32'hC0B);
    tick();
    checkOutput("drain_c", out_data, 32'hC0C);
    tick();
    checkOutput("drain_idle", out_vld, 0);
    doReset();

    // reset while FIFOs and output hold packets
    out_rdy = 1'b0;
    applyStimulus(1, 1, 0, 2'd0, 4'd1, 4'd2, 32'hD01);
    applyStimulus(3, 1, 1, 2'd0, 4'd3, 4'd2, 32'hD03);
    tick();
    in_vld = '0;
    tick();
    tick();
    checkOutput("prerst_vld", out_vld, 1);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_vld", out_vld, 0);
    checkOutput("midrst_port", out_port, 0);
    checkOutput("midrst_data", out_data, 0);
    checkOutput("midrst_in_rdy", in_rdy, 7'h7f);
    tick();
    rst_n = 1'b1;
    out_rdy = 1'b1;
    for (int c = 0; c < 4; c++) begin
      checkOutput("postrst_idle", out_vld, 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
